// File: rtl/fmap_serializer.sv
// Feature-map serializer: snapshots a SIZE x SIZE map on a rising edge of done
// and streams it element by element, row-major, over a valid/ready handshake.
module fmap_serializer #(
  parameter int SIZE      = 12,
  parameter int WIDTH_BIT = 16
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic                                            done,
  input  logic signed [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] matrixIn,
  output logic signed [WIDTH_BIT-1:0]                     outData,
  output logic                                            outValid,
  input  logic                                            outReady,
  output logic                                            outLast,
  output logic [$clog2(SIZE)-1:0]                         outRow,
  output logic [$clog2(SIZE)-1:0]                         outCol,
  output logic                                            busy,
  output logic                                            frameDone,
  output logic                                            dropped
);
  localparam int            IW       = $clog2(SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;
  state_t state_reg, state_next;

  logic                 done_q_reg;
  logic [IW-1:0]        row_reg, col_reg;
  logic [IW-1:0]        row_next, col_next;
  logic [WIDTH_BIT-1:0] data_reg;
  logic                 frame_done_reg;
  logic                 dropped_reg;
  logic [WIDTH_BIT-1:0] buffer_reg [SIZE][SIZE];

  logic capture_req, streaming, at_last, xfer, last_xfer, load;

  assign capture_req = done & ~done_q_reg;
  assign streaming   = (state_reg == STREAM);
  assign at_last     = streaming & (row_reg == LAST_IDX) & (col_reg == LAST_IDX);
  assign xfer        = streaming & outReady;
  assign last_xfer   = xfer & at_last;
  // A capture landing on the final transfer chains straight into the next frame.
  assign load        = capture_req & (~streaming | last_xfer);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (capture_req) state_next = STREAM;
      STREAM:  if (last_xfer && !capture_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    outValid  = streaming;
    busy      = streaming;
    outLast   = at_last;
    outData   = streaming ? data_reg : '0;
    outRow    = streaming ? row_reg : '0;
    outCol    = streaming ? col_reg : '0;
    frameDone = frame_done_reg;
    dropped   = dropped_reg;
  end

  always_comb begin
    row_next = row_reg;
    col_next = col_reg + 1'b1;
    if (col_reg == LAST_IDX) begin
      col_next = '0;
      row_next = row_reg + 1'b1;
    end
  end

  // Snapshot storage: no reset, contents only matter after a load.
  always_ff @(posedge clock) begin
    if (load) begin
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE; j++) begin
          buffer_reg[i][j] <= matrixIn[i][j];
        end
      end
    end
  end

  // outData is a registered read: the next element is fetched on the accepting edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      done_q_reg     <= 1'b0;
      row_reg        <= '0;
      col_reg        <= '0;
      data_reg       <= '0;
      frame_done_reg <= 1'b0;
      dropped_reg    <= 1'b0;
    end else begin
      done_q_reg     <= done;
      frame_done_reg <= last_xfer;
      if (capture_req && streaming && !last_xfer) begin
        dropped_reg <= 1'b1;
      end
      if (load) begin
        row_reg  <= '0;
        col_reg  <= '0;
        data_reg <= matrixIn[0][0];
      end else if (last_xfer) begin
        row_reg  <= '0;
        col_reg  <= '0;
        data_reg <= '0;
      end else if (xfer) begin
        row_reg  <= row_next;
        col_reg  <= col_next;
        data_reg <= buffer_reg[row_next][col_next];
      end
    end
  end
endmodule
